gate_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the demux-based AND/OR gate block (or_and).
- On a start pulse, drives the gate block's a/b inputs through all four input vectors (00, 01, 10, 11) for NUM_PASSES passes.
- Samples the and/or outputs after a programmable settle time and compares them against golden values.
- Reports pass/fail, a saturating error count, and the first failing vector. Sits beside or_and in the top level; the gate block is instantiated externally.

---
 rtl/gate_bist_pkg.sv | 19 +
 rtl/gate_bist_ctrl.sv | 121 ++++++++++++
 tb/tb_gate_bist_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the AND/OR gate block self-test sequencer.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Golden response of a healthy gate block: {and, or} for vector {a, b}.
  function automatic logic [1:0] golden(input logic [1:0] vec);
    return {vec[1] & vec[0], vec[1] | vec[0]};
  endfunction

endpackage

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer: sweeps {a,b} over all four vectors for
// NUM_PASSES passes, checks the gate block's and/or outputs after a settle
// delay, and reports pass/fail, a saturating error count and the first
// failing vector.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_and,
  input  logic             gate_or,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned PASS_W   = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [PASS_W-1:0]   LAST_PASS   = PASS_W'(NUM_PASSES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [1:0]          LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t              state;
  state_t              state_next;
  logic [1:0]          vec_idx;
  logic [PASS_W-1:0]   pass_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                mismatch;
  logic                last_vec;

  // One failing vector is counted whether one or both outputs disagree.
  assign mismatch = ({gate_and, gate_or} != golden({gate_a, gate_b}));
  assign last_vec = (vec_idx == LAST_VEC) && (pass_cnt == LAST_PASS);

  assign busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = (SETTLE_CYCLES > 0) ? WAIT : CHECK;
      WAIT:    if (settle_cnt == SETTLE_W'(1)) state_next = CHECK;
      CHECK:   state_next = last_vec ? DONE : APPLY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector sequencing, settle timing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_a           <= 1'b0;
      gate_b           <= 1'b0;
      vec_idx          <= '0;
      pass_cnt         <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass_cnt         <= '0;
            vec_idx          <= '0;
            gate_a           <= 1'b0;
            gate_b           <= 1'b0;
          end
        end
        APPLY: settle_cnt <= SETTLE_LOAD;
        WAIT:  settle_cnt <= settle_cnt - SETTLE_W'(1);
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (!first_fail_valid) begin
              first_fail_vec   <= {gate_a, gate_b};
              first_fail_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else begin
            vec_idx <= vec_idx + 2'd1;
            if (vec_idx == LAST_VEC) pass_cnt <= pass_cnt + PASS_W'(1);
            {gate_a, gate_b} <= vec_idx + 2'd1;
          end
        end
        DONE: pass <= (err_count == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: four configurations run side by
// side against a timeline-based reference model, plus directed sequences.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  localparam int unsigned NP_T   [4] = '{1, 5, 1, 1};
  localparam int unsigned ST_T   [4] = '{1, 1, 0, 3};
  localparam int unsigned EMAX_T [4] = '{15, 3, 15, 15};

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic       dut_a    [4];
  logic       dut_b    [4];
  logic       dut_and  [4];
  logic       dut_or   [4];
  logic       dut_busy [4];
  logic       dut_done [4];
  logic       dut_pass [4];
  logic       dut_ffv  [4];
  logic [1:0] dut_ffvec[4];
  logic [3:0] dut_err  [4];
  logic [3:0] err0, err2, err3;
  logic [1:0] err1;

  // Fault injection: XOR mask on {and, or} per applied vector {a, b}.
  logic [1:0] mask [4][4];

  assign dut_err[0] = err0;
  assign dut_err[1] = {2'b00, err1};
  assign dut_err[2] = err2;
  assign dut_err[3] = err3;

  for (genvar g = 0; g < 4; g++) begin : gm
    assign {dut_and[g], dut_or[g]} = golden({dut_a[g], dut_b[g]}) ^ mask[g][{dut_a[g], dut_b[g]}];
  end

  gate_bist_ctrl #(.NUM_PASSES(1), .SETTLE_CYCLES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .gate_a(dut_a[0]), .gate_b(dut_b[0]),
    .gate_and(dut_and[0]), .gate_or(dut_or[0]), .busy(dut_busy[0]), .done(dut_done[0]),
    .pass(dut_pass[0]), .err_count(err0), .first_fail_vec(dut_ffvec[0]),
    .first_fail_valid(dut_ffv[0]));
  gate_bist_ctrl #(.NUM_PASSES(5), .SETTLE_CYCLES(1), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .gate_a(dut_a[1]), .gate_b(dut_b[1]),
    .gate_and(dut_and[1]), .gate_or(dut_or[1]), .busy(dut_busy[1]), .done(dut_done[1]),
    .pass(dut_pass[1]), .err_count(err1), .first_fail_vec(dut_ffvec[1]),
    .first_fail_valid(dut_ffv[1]));
  gate_bist_ctrl #(.NUM_PASSES(1), .SETTLE_CYCLES(0), .ERR_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .gate_a(dut_a[2]), .gate_b(dut_b[2]),
    .gate_and(dut_and[2]), .gate_or(dut_or[2]), .busy(dut_busy[2]), .done(dut_done[2]),
    .pass(dut_pass[2]), .err_count(err2), .first_fail_vec(dut_ffvec[2]),
    .first_fail_valid(dut_ffv[2]));
  gate_bist_ctrl #(.NUM_PASSES(1), .SETTLE_CYCLES(3), .ERR_W(4)) u3 (
    .clk(clk), .rst(rst), .start(start), .gate_a(dut_a[3]), .gate_b(dut_b[3]),
    .gate_and(dut_and[3]), .gate_or(dut_or[3]), .busy(dut_busy[3]), .done(dut_done[3]),
    .pass(dut_pass[3]), .err_count(err3), .first_fail_vec(dut_ffvec[3]),
    .first_fail_valid(dut_ffv[3]));

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic        check_en = 1'b0;

  // Reference model: m_t is the cycle number within a run (0 = idle).
  int unsigned m_t    [4];
  int unsigned m_err  [4];
  logic        m_ffv  [4];
  logic [1:0]  m_ffvec[4];
  logic        m_pass [4];

  task automatic model_step(input int i);
    int unsigned per, total, k, ph;
    logic [1:0] v;
    per   = 2 + ST_T[i];
    total = 4 * NP_T[i] * per;
    if (rst) begin
      m_t[i] = 0; m_err[i] = 0; m_ffv[i] = 1'b0; m_ffvec[i] = 2'b00; m_pass[i] = 1'b0;
    end else if (m_t[i] == 0) begin
      if (start) begin
        m_t[i] = 1; m_err[i] = 0; m_ffv[i] = 1'b0; m_ffvec[i] = 2'b00;
      end
    end else if (m_t[i] == total + 1) begin
      m_pass[i] = (m_err[i] == 0);
      m_t[i]    = 0;
    end else begin
      k  = (m_t[i] - 1) / per;
      ph = (m_t[i] - 1) % per;
      if (ph == per - 1) begin
        v = 2'(k % 4);
        if (mask[i][v] != 2'b00) begin
          if (m_err[i] < EMAX_T[i]) m_err[i] = m_err[i] + 1;
          if (!m_ffv[i]) begin
            m_ffv[i]   = 1'b1;
            m_ffvec[i] = v;
          end
        end
      end
      m_t[i] = m_t[i] + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) model_step(i);
  end

  function automatic logic [11:0] exp_obs(input int i);
    int unsigned per, total;
    logic bz, dn;
    logic [1:0] ab;
    per   = 2 + ST_T[i];
    total = 4 * NP_T[i] * per;
    bz = (m_t[i] >= 1) && (m_t[i] <= total);
    dn = (m_t[i] == total + 1);
    ab = bz ? 2'(((m_t[i] - 1) / per) % 4) : 2'b00;
    return {ab, bz, dn, m_pass[i], m_ffv[i], m_ffvec[i], 4'(m_err[i])};
  endfunction

  function automatic logic [11:0] dut_obs(input int i);
    return {dut_a[i], dut_b[i], dut_busy[i], dut_done[i], dut_pass[i], dut_ffv[i],
            dut_ffvec[i], dut_err[i]};
  endfunction

  // Cycle-by-cycle scoreboard for every instance.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_obs(i) !== exp_obs(i)) begin
          failures++;
          $display("FAIL model_u%0d t=%0t actual={ab,busy,done,pass,ffv,ffvec,err}=%b required=%b",
                   i, $time, dut_obs(i), exp_obs(i));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic all_idle();
    logic r = 1'b1;
    for (int i = 0; i < 4; i++) if (dut_busy[i] || dut_done[i]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_all_idle(input int unsigned bound);
    int unsigned n = 0;
    while (!all_idle() && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(all_idle()), 32'd1);
  endtask

  task automatic clear_masks();
    for (int i = 0; i < 4; i++)
      for (int v = 0; v < 4; v++) mask[i][v] = 2'b00;
  endtask

  typedef struct {
    logic       start_in;
    logic [1:0] ab;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [14];
  int unsigned dcyc [4];

  initial begin
    // Healthy default run: start before edge 1, expectations after each edge.
    tbl[0]  = '{1'b1, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b0};

    clear_masks();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_u%0d", i), 32'(dut_obs(i)), 32'd0);
    rst      = 1'b0;
    check_en = 1'b1;

    // Healthy u0/u2/u3, gate_or stuck-at-1 on u1.
    mask[1][0] = 2'b01;
    for (int i = 0; i < 4; i++) dcyc[i] = 0;
    for (int c = 0; c < 70; c++) begin
      start = (c < 14) ? tbl[c].start_in : 1'b0;
      @(negedge clk);
      if (c < 14) begin
        chk($sformatf("tbl_ab_c%0d", c + 1), 32'({dut_a[0], dut_b[0]}), 32'(tbl[c].ab));
        chk($sformatf("tbl_busy_c%0d", c + 1), 32'(dut_busy[0]), 32'(tbl[c].busy));
        chk($sformatf("tbl_done_c%0d", c + 1), 32'(dut_done[0]), 32'(tbl[c].done));
      end
      for (int i = 0; i < 4; i++) if (dut_done[i] && dcyc[i] == 0) dcyc[i] = c + 1;
    end
    chk("done_cycle_default", dcyc[0], 32'd13);
    chk("done_cycle_5pass", dcyc[1], 32'd61);
    chk("done_cycle_settle0", dcyc[2], 32'd9);
    chk("done_cycle_settle3", dcyc[3], 32'd21);
    chk("healthy_pass", 32'(dut_pass[0]), 32'd1);
    chk("healthy_err", 32'(dut_err[0]), 32'd0);
    chk("healthy_ffv", 32'(dut_ffv[0]), 32'd0);
    chk("sa1_err_sat", 32'(dut_err[1]), 32'd3);
    chk("sa1_ffvec", 32'(dut_ffvec[1]), 32'd0);
    chk("sa1_ffv", 32'(dut_ffv[1]), 32'd1);
    chk("sa1_pass", 32'(dut_pass[1]), 32'd0);
    chk("settle0_pass", 32'(dut_pass[2]), 32'd1);
    chk("settle3_pass", 32'(dut_pass[3]), 32'd1);
    wait_all_idle(100);

    // gate_and stuck-at-0 on u0: only vector 11 disagrees.
    clear_masks();
    mask[0][3] = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_all_idle(100);
    chk("sa0_err", 32'(dut_err[0]), 32'd1);
    chk("sa0_ffvec", 32'(dut_ffvec[0]), 32'd3);
    chk("sa0_ffv", 32'(dut_ffv[0]), 32'd1);
    chk("sa0_pass", 32'(dut_pass[0]), 32'd0);

    // Re-pulsed start during the run, then held high across DONE.
    for (int c = 0; c < 15; c++) begin
      start = (c == 0) || (c == 4) || (c >= 13);
      @(negedge clk);
      if (c == 12) begin
        chk("restart_done13", 32'(dut_done[0]), 32'd1);
        chk("restart_err1", 32'(dut_err[0]), 32'd1);
      end
      if (c == 13) chk("restart_idle14", 32'({dut_busy[0], dut_done[0]}), 32'd0);
      if (c == 14) begin
        chk("restart_busy15", 32'(dut_busy[0]), 32'd1);
        chk("restart_err_clr", 32'(dut_err[0]), 32'd0);
      end
    end
    start = 1'b0;
    wait_all_idle(100);

    // Reset in the middle of a healthy run, then a clean run.
    clear_masks();
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      rst   = (c == 5);
      @(negedge clk);
    end
    chk("midrst_outputs", 32'(dut_obs(0)), 32'd0);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_all_idle(100);
    chk("after_rst_pass", 32'(dut_pass[0]), 32'd1);

    // Randomized faults, start and reset activity.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++)
        for (int v = 0; v < 4; v++)
          mask[i][v] = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
      for (int n = 0; n < int'($urandom_range(120, 20)); n++) begin
        start = ($urandom_range(5) == 0);
        rst   = ($urandom_range(79) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      wait_all_idle(200);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
